imem_loader: RTL and testbench
==============================

# imem_loader

Boot-time writer for the instruction memory. Receives a byte stream (length header plus little-endian instruction words) over a valid/ready interface, assembles 32-bit words and drives the instruction memory write port at sequential word addresses from 0. Holds the core in reset until the image is complete. Sits between the boot byte source (UART receiver or testbench) and the write side of the instruction memory.

## Interface
- InstLength, 256, instruction memory depth in words; maximum accepted image length.
- clk  input  1  single clock; all state changes on rising edge.
- rst  input  1  reset, synchronous, active-high.
- start  input  1  one-cycle pulse; restarts loading from the DONE or ERR state; ignored in other states.
- byte_valid  input  1  byte_data is valid.
- byte_data  input  8  stream byte.
- byte_ready  output  1  loader accepts a byte this cycle; a byte transfers when byte_valid && byte_ready at a rising edge.
- we_IM  output  1  instruction memory write enable, one-cycle pulse per word.
- waddr_IM  output  32  byte address of the write, always word-aligned (bits [1:0] = 0).
- wdata_IM  output  32  word to write.
- cpu_hold  output  1  high keeps the core in reset; equals !done.
- done  output  1  image fully written (and verified if the checksum is compiled in).
- error  output  1  load aborted.

## Operation
- States: LEN, DATA, CHK (checksum builds only), DONE, ERR.
- LEN: accept 4 bytes, little-endian, into a 32-bit word count N. After the 4th byte:
  - N == 0: go to DONE (to CHK if checksum is enabled).
  - N > InstLength: go to ERR.
  - otherwise: go to DATA, word index = 0.
- DATA: accept bytes into a byte lane counter 0..3; byte k fills bits [8k+7:8k]. On the 4th byte, register a write (we_IM=1, waddr_IM = index*4, wdata_IM = assembled word) and increment the index. After word N-1 is written, go to DONE (to CHK if checksum is enabled).
- DONE: done=1, byte_ready=0. Stays here until start or rst.
- ERR: error=1, done=0, byte_ready=0. Stays here until start or rst.
- start in DONE or ERR: go to LEN; clear the lane counter, index, N, and the checksum accumulator; done and error drop.
- byte_ready=1 in LEN, DATA and CHK; 0 otherwise. Bytes presented while byte_ready=0 are not consumed.
- Index width holds 0..InstLength. The N > InstLength check guarantees that the address never exceeds (InstLength-1)*4, so no wrap-around occurs.

## Timing
- Reset values: state=LEN, byte_ready=1, we_IM=0, waddr_IM=0, wdata_IM=0, done=0, error=0, cpu_hold=1; all counters 0.
- Reset mid-load discards the partial image and returns to LEN. Words already written are not cleared.
- Write latency: the edge that accepts the 4th byte of a word asserts we_IM, waddr_IM and wdata_IM for exactly the following cycle. waddr_IM and wdata_IM hold their values after the pulse.
- Back-to-back bytes are accepted every cycle. The minimum spacing between we_IM pulses is 4 cycles.
- done (and the cpu_hold deassertion) rises one cycle after the final we_IM pulse, so the last write has committed before the core leaves reset. For N=0, done rises on the cycle after the 4th length byte.
- A start coincident with rst is ignored; rst wins.

## Configuration
- IMEM_LOADER_CHECKSUM_EN defined:
  - After the N data words, state CHK accepts 4 more bytes (little-endian): the expected sum of all data words, mod 2^32.
  - Match: DONE. Mismatch: ERR.
  - done rises one cycle after the 4th checksum byte is accepted.
- Undefined:
  - There is no CHK state and no accumulator.
  - DONE follows the last data word directly.

## Test plan
- Reset, then stream 02 00 00 00, 13 00 00 00, 93 00 10 00 back-to-back. Expect:
  - we_IM pulses with addr 0x0 / data 0x00000013, then addr 0x4 / data 0x00100093.
  - done=1 one cycle after the 2nd pulse; cpu_hold=0.
- Length 00 01 00 00 (N=256) followed by 256 words with byte_valid toggling randomly. Expect:
  - 256 writes, last at 0x3FC.
  - done=1; no byte lost or duplicated.
- Length 01 01 00 00 (N=257). Expect ERR, error=1, byte_ready=0, no we_IM pulses. Then pulse start: state LEN, error=0.
- Length 00 00 00 00. Expect done one cycle after the 4th byte and zero writes (checksum build: done after 4 checksum bytes 00 00 00 00).
- Assert rst after 2 of 4 bytes of word 1. Expect all outputs at reset values, and a fresh stream loads correctly from address 0.
- Checksum build, words 0x00000013 and 0x00100093:
  - Checksum bytes A6 00 10 00: expect done.
  - Checksum bytes A7 00 10 00: expect error=1, done=0, cpu_hold=1.

Source files
------------

// File: rtl/imem_loader.sv
// Boot loader: length-prefixed little-endian byte stream -> instruction memory writes.
// Optional trailing checksum word enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int InstLength = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        we_IM,
  output logic [31:0] waddr_IM,
  output logic [31:0] wdata_IM,
  output logic        cpu_hold,
  output logic        done,
  output logic        error
);
  localparam int IdxW = $clog2(InstLength + 1);

  typedef enum logic [2:0] {S_LEN, S_DATA, S_CHK, S_DONE, S_ERR} state_t;

  state_t          state_q, state_d, fin_state;
  logic [1:0]      lane_q, lane_d;
  logic [23:0]     part_q, part_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic [31:0]     len_q, len_d;
  logic            we_q, we_d;
  logic [31:0]     waddr_q, waddr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic            take, last_byte;
  logic [31:0]     word;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0]     acc_q, acc_d;
  assign fin_state = S_CHK;
`else
  assign fin_state = S_DONE;
`endif

  assign byte_ready = (state_q == S_LEN) || (state_q == S_DATA) || (state_q == S_CHK);
  assign take       = byte_valid && byte_ready;
  assign last_byte  = take && (lane_q == 2'd3);
  assign word       = {byte_data, part_q};

  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    part_d  = part_q;
    idx_d   = idx_q;
    len_d   = len_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    acc_d   = acc_q;
`endif
    if (take) begin
      lane_d = lane_q + 2'd1;
      part_d = {byte_data, part_q[23:8]};
    end
    case (state_q)
      S_LEN: if (last_byte) begin
        len_d = word;
        idx_d = '0;
        if (word == 32'd0)                   state_d = fin_state;
        else if (word > 32'(InstLength))     state_d = S_ERR;
        else                                 state_d = S_DATA;
      end
      S_DATA: if (last_byte) begin
        we_d    = 1'b1;
        waddr_d = {{(30 - IdxW){1'b0}}, idx_q, 2'b00};
        wdata_d = word;
        idx_d   = idx_q + 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
        acc_d   = acc_q + word;
`endif
        if (32'(idx_q) + 32'd1 == len_q) state_d = fin_state;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHK: if (last_byte) state_d = (word == acc_q) ? S_DONE : S_ERR;
`endif
      S_DONE, S_ERR: if (start) begin
        state_d = S_LEN;
        lane_d  = 2'd0;
        idx_d   = '0;
        len_d   = 32'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        acc_d   = 32'd0;
`endif
      end
      default: state_d = S_LEN;
    endcase
  end

  // Status flags lag state entry by one cycle so the final write commits first,
  // but drop on the same edge that leaves DONE/ERR.
  assign done_d = (state_q == S_DONE) && (state_d == S_DONE);
  assign err_d  = (state_q == S_ERR)  && (state_d == S_ERR);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_LEN;
      lane_q  <= 2'd0;
      part_q  <= 24'd0;
      idx_q   <= '0;
      len_q   <= 32'd0;
      we_q    <= 1'b0;
      waddr_q <= 32'd0;
      wdata_q <= 32'd0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      acc_q   <= 32'd0;
`endif
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      part_q  <= part_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      done_q  <= done_d;
      err_q   <= err_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      acc_q   <= acc_d;
`endif
    end
  end

  assign we_IM    = we_q;
  assign waddr_IM = waddr_q;
  assign wdata_IM = wdata_q;
  assign done     = done_q;
  assign error    = err_q;
  assign cpu_hold = !done_q;
endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes queued as words are sent,
// popped and compared whenever the loader pulses we_IM.
module tb_imem_loader;
  logic        clk = 1'b0;
  logic        rst, start, byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready, we_IM, cpu_hold, done, error;
  logic [31:0] waddr_IM, wdata_IM;

  imem_loader #(.InstLength(256)) dut (
    .clk(clk), .rst(rst), .start(start), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_ready(byte_ready), .we_IM(we_IM), .waddr_IM(waddr_IM), .wdata_IM(wdata_IM),
    .cpu_hold(cpu_hold), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  int          checks = 0;
  int          errors = 0;
  int          nwrites = 0;
  int          gap_max = 0;
  logic [31:0] last_addr = '0;
  logic [31:0] img[$];
  wr_t         exp_q[$];

  always @(negedge clk) begin
    wr_t e;
    if (we_IM) begin
      nwrites++;
      last_addr = waddr_IM;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write addr=%h data=%h", waddr_IM, wdata_IM);
      end else begin
        e = exp_q.pop_front();
        if ({waddr_IM, wdata_IM} !== e) begin
          errors++;
          $display("FAIL write got addr=%h data=%h want addr=%h data=%h",
                   waddr_IM, wdata_IM, e.addr, e.data);
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    byte_valid = 1'b0;
    repeat ($urandom_range(0, gap_max)) begin @(posedge clk); #1; end
    byte_valid = 1'b1;
    byte_data  = b;
    while (!byte_ready && t < 100) begin @(posedge clk); #1; t++; end
    if (t >= 100) begin
      checks++; errors++;
      $display("FAIL send_timeout byte_ready=%b want 1", byte_ready);
    end
    @(posedge clk); #1;
    byte_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8]);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Length, data words (queued as expected writes), and checksum when compiled in.
  task automatic load(input int n, input bit bad_sum);
    logic [31:0] s = '0;
    send_word(32'(n));
    for (int i = 0; i < n; i++) begin
      send_word(img[i]);
      exp_q.push_back({32'(i * 4), img[i]});
      s += img[i];
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_word(s + {31'd0, bad_sum});
`else
    if (bad_sum && s == 32'hFFFF_FFFF) $display("note: sum wraps");
`endif
  endtask

  task automatic wait_done(input string name);
    int t = 0;
    while (!done && t < 50) begin @(posedge clk); #1; t++; end
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL %s done=%b want 1", name, done); end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL %s pending_writes=%0d want 0", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({byte_ready, we_IM, done, error, cpu_hold} !== 5'b10001) begin
      errors++;
      $display("FAIL reset_flags ready/we/done/err/hold=%b want 10001",
               {byte_ready, we_IM, done, error, cpu_hold});
    end
    checks++;
    if ({waddr_IM, wdata_IM} !== 64'd0) begin
      errors++; $display("FAIL reset_bus addr=%h data=%h want 0", waddr_IM, wdata_IM);
    end
  endtask

  task automatic test_basic();
    gap_max = 0;
    send_word(32'd2);
    send_word(32'h0000_0013);
    exp_q.push_back({32'h0, 32'h0000_0013});
    send_word(32'h0010_0093);
    exp_q.push_back({32'h4, 32'h0010_0093});
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_word(32'h0010_00A6);
`else
    checks++;
    if (we_IM !== 1'b1) begin errors++; $display("FAIL basic_we we_IM=%b want 1", we_IM); end
`endif
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL basic_done_early done=%b want 0", done); end
    @(posedge clk); #1;
    checks++;
    if ({done, cpu_hold} !== 2'b10) begin
      errors++; $display("FAIL basic_done done/hold=%b want 10", {done, cpu_hold});
    end
    checks++;
    if (nwrites != 2) begin errors++; $display("FAIL basic_writes got %0d want 2", nwrites); end
  endtask

  task automatic test_max();
    int w0;
    pulse_start();
    checks++;
    if ({done, cpu_hold, byte_ready} !== 3'b011) begin
      errors++; $display("FAIL start_clear done/hold/ready=%b want 011", {done, cpu_hold, byte_ready});
    end
    img.delete();
    for (int i = 0; i < 256; i++) img.push_back($urandom());
    gap_max = 2;
    w0 = nwrites;
    load(256, 1'b0);
    gap_max = 0;
    wait_done("max");
    checks++;
    if (nwrites - w0 != 256) begin
      errors++; $display("FAIL max_count got %0d want 256", nwrites - w0);
    end
    checks++;
    if (last_addr !== 32'h3FC) begin
      errors++; $display("FAIL max_last_addr got %h want 000003fc", last_addr);
    end
  endtask

  task automatic test_overlength();
    int w0;
    pulse_start();
    w0 = nwrites;
    send_word(32'd257);
    repeat (2) begin @(posedge clk); #1; end
    checks++;
    if ({error, done, byte_ready, cpu_hold} !== 4'b1001) begin
      errors++;
      $display("FAIL overlen_flags err/done/ready/hold=%b want 1001",
               {error, done, byte_ready, cpu_hold});
    end
    checks++;
    if (nwrites != w0) begin errors++; $display("FAIL overlen_writes got %0d want 0", nwrites - w0); end
    pulse_start();
    checks++;
    if ({error, byte_ready} !== 2'b01) begin
      errors++; $display("FAIL overlen_restart err/ready=%b want 01", {error, byte_ready});
    end
  endtask

  task automatic test_zero();
    int w0;
    w0 = nwrites;
    img.delete();
    load(0, 1'b0);
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL zero_done_early done=%b want 0", done); end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL zero_done done=%b want 1", done); end
    repeat (2) begin @(posedge clk); #1; end
    checks++;
    if (nwrites != w0) begin errors++; $display("FAIL zero_writes got %0d want 0", nwrites - w0); end
  endtask

  task automatic test_reset_mid();
    pulse_start();
    send_word(32'd2);
    send_word(32'hDEAD_BEEF);
    exp_q.push_back({32'h0, 32'hDEAD_BEEF});
    send_byte(8'h11);
    send_byte(8'h22);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    test_reset();
    img.delete();
    img.push_back(32'h1234_5678);
    img.push_back(32'h9ABC_DEF0);
    load(2, 1'b0);
    wait_done("reset_mid");
  endtask

  task automatic test_start_ignored();
    pulse_start();
    send_word(32'd1);
    send_byte(8'h0D);
    send_byte(8'hF0);
    pulse_start();
    send_byte(8'hFE);
    send_byte(8'hCA);
    exp_q.push_back({32'h0, 32'hCAFE_F00D});
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_word(32'hCAFE_F00D);
`endif
    wait_done("start_ignored");
  endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    img.delete();
    img.push_back(32'h0000_0013);
    img.push_back(32'h0010_0093);
    pulse_start();
    load(2, 1'b0);
    wait_done("chk_good");
    pulse_start();
    load(2, 1'b1);
    repeat (2) begin @(posedge clk); #1; end
    checks++;
    if ({error, done, cpu_hold} !== 3'b101) begin
      errors++; $display("FAIL chk_bad err/done/hold=%b want 101", {error, done, cpu_hold});
    end
  endtask
`endif

  initial begin
    rst = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    rst = 1'b0;
    test_reset();
    test_basic();
    test_max();
    test_overlength();
    test_zero();
    test_reset_mid();
    test_start_ignored();
`ifdef IMEM_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
